// File: rtl/slave_i2c_rx.sv
// Receiving end of the I2C-style link: synchronizes SDA/SCL, detects START/STOP,
// shifts in SIZE data bits LSB first plus a pad bit, and emits one-cycle valid/error pulses.
module slave_i2c_rx #(
    parameter int SIZE        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            SDA,
    input  logic            SCL,
    output logic [SIZE-1:0] data_out,
    output logic            data_valid,
    output logic            frame_err,
    output logic            busy,
    output logic [1:0]      state_o
);

    localparam int CNT_W = $clog2(SIZE + 2);
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        STOPW = 2'd2
    } state_t;

    // Synchronizers and previous samples reset high so release looks like an idle bus.
    logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
    logic                   sda_p_q, scl_p_q;
    logic                   sda_s, scl_s;

    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign scl_s = scl_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
            sda_p_q    <= 1'b1;
            scl_p_q    <= 1'b1;
        end else begin
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_p_q    <= sda_s;
            scl_p_q    <= scl_s;
        end
    end

    // SCL must be high in both samples, so an SDA change coinciding with an SCL fall is ignored.
    logic start_ev, stop_ev, rise_ev;
    assign start_ev = scl_p_q & scl_s & sda_p_q & ~sda_s;
    assign stop_ev  = scl_p_q & scl_s & ~sda_p_q & sda_s;
    assign rise_ev  = ~scl_p_q & scl_s;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   shift_q, shift_d;
    logic              pad_q, pad_d;
    logic [SIZE-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            pad_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pad_q   <= pad_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pad_d   = pad_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (start_ev) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else if (stop_ev) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise_ev) begin
                    if (cnt_q < SIZE_C) begin
                        for (int i = 0; i < SIZE; i++) begin
                            if (cnt_q == CNT_W'(i)) shift_d[i] = sda_s;
                        end
                    end else begin
                        pad_d = sda_s;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == SIZE_C) state_d = STOPW;
                end
            end
            STOPW: begin
                if (stop_ev) begin
                    if (!pad_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise_ev) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start_ev) begin
                    err_d   = 1'b1;
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_slave_i2c_rx.sv
// Directed bench for slave_i2c_rx: bus driven with 4-clk bits (SCL high 2 clk),
// pulses captured by a monitor and compared against hand-computed expectations.
module tb_slave_i2c_rx;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            SDA;
    logic            SCL;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            frame_err;
    logic            busy;
    logic [1:0]      state_o;

    slave_i2c_rx #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .SDA        (SDA),
        .SCL        (SCL),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Monitor: samples just after each rising edge, counts pulses and logs received words.
    int              valid_total = 0;
    int              err_total = 0;
    int              both_total = 0;
    int              dout_chg_total = 0;
    logic [SIZE-1:0] dout_prev = '0;
    logic [SIZE-1:0] captured[64];

    always @(posedge clk) begin
        #2;
        if (reset_n) begin
            if (data_valid && frame_err) both_total = both_total + 1;
            if (data_valid) begin
                if (valid_total < 64) captured[valid_total] = data_out;
                valid_total = valid_total + 1;
            end
            if (frame_err) err_total = err_total + 1;
            if (!data_valid && (data_out !== dout_prev)) dout_chg_total = dout_chg_total + 1;
        end
        dout_prev = data_out;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        SCL = 1'b0;
        SDA = b;
        wait_clk(2);
        SCL = 1'b1;
        wait_clk(2);
    endtask

    task automatic start_cond(input logic from_idle);
        if (!from_idle) begin
            SCL = 1'b0;
            SDA = 1'b1;
            wait_clk(2);
            SCL = 1'b1;
            wait_clk(2);
        end
        SDA = 1'b0;
        wait_clk(2);
    endtask

    // Called with SCL high; adds a clock cycle only when SDA must first be brought low.
    task automatic stop_cond();
        if (SDA !== 1'b0) begin
            SCL = 1'b0;
            SDA = 1'b0;
            wait_clk(2);
            SCL = 1'b1;
            wait_clk(2);
        end
        SDA = 1'b1;
        wait_clk(2);
    endtask

    task automatic send_frame(input logic [SIZE-1:0] d, input logic pad, input logic from_idle);
        start_cond(from_idle);
        for (int i = 0; i < SIZE; i++) send_bit(d[i]);
        send_bit(pad);
        stop_cond();
    endtask

    typedef struct {
        logic [SIZE-1:0] data;
        logic            pad;
        int              exp_valid;
        int              exp_err;
        logic [SIZE-1:0] exp_dout;
    } vec_t;

    vec_t            vecs[5];
    logic [SIZE-1:0] exp_q[$];
    int              v0, e0;

    initial begin
        vecs[0] = '{data: 8'hA5, pad: 1'b0, exp_valid: 1, exp_err: 0, exp_dout: 8'hA5};
        vecs[1] = '{data: 8'h00, pad: 1'b0, exp_valid: 1, exp_err: 0, exp_dout: 8'h00};
        vecs[2] = '{data: 8'hFF, pad: 1'b0, exp_valid: 1, exp_err: 0, exp_dout: 8'hFF};
        vecs[3] = '{data: 8'h3C, pad: 1'b1, exp_valid: 0, exp_err: 1, exp_dout: 8'hFF};
        vecs[4] = '{data: 8'h81, pad: 1'b0, exp_valid: 1, exp_err: 0, exp_dout: 8'h81};

        // Reset state
        reset_n = 1'b0;
        SDA = 1'b1;
        SCL = 1'b1;
        wait_clk(3);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        reset_n = 1'b1;
        wait_clk(4);

        // Table of complete frames
        for (int k = 0; k < 5; k++) begin
            v0 = valid_total;
            e0 = err_total;
            send_frame(vecs[k].data, vecs[k].pad, 1'b1);
            wait_clk(6);
            check($sformatf("vec%0d_valid_cnt", k), 32'(valid_total - v0), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_err_cnt", k), 32'(err_total - e0), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_data_out", k), 32'(data_out), 32'(vecs[k].exp_dout));
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'h0);
        end

        // Back-to-back frames, STOP and next START 2 clk apart
        v0 = valid_total;
        e0 = err_total;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_clk(6);
        check("b2b_valid_cnt", 32'(valid_total - v0), 32'd2);
        check("b2b_err_cnt", 32'(err_total - e0), 32'd0);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("b2b_word%0d", j), 32'(captured[(v0 + j) % 64]), 32'(exp_q.pop_front()));
        end

        // Short frame: START, 4 bits, STOP, then a good frame
        v0 = valid_total;
        e0 = err_total;
        start_cond(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_clk(2);
        check("short_busy_mid", 32'(busy), 32'h1);
        check("short_state_mid", 32'(state_o), 32'h1);
        send_bit(1'b0);
        stop_cond();
        wait_clk(6);
        check("short_err_cnt", 32'(err_total - e0), 32'd1);
        check("short_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("short_busy", 32'(busy), 32'h0);
        check("short_data_held", 32'(data_out), 32'hFF);
        v0 = valid_total;
        send_frame(8'h81, 1'b0, 1'b1);
        wait_clk(6);
        check("after_short_valid", 32'(valid_total - v0), 32'd1);
        check("after_short_data", 32'(data_out), 32'h81);

        // Repeated START after 5 bits, then full 0x5A with exact STOP latency
        v0 = valid_total;
        e0 = err_total;
        start_cond(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        start_cond(1'b0);
        wait_clk(2);
        check("restart_err_cnt", 32'(err_total - e0), 32'd1);
        check("restart_busy", 32'(busy), 32'h1);
        for (int i = 0; i < SIZE; i++) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
        send_bit(1'b0);
        SDA = 1'b1;
        wait_clk(2);
        check("lat_valid_early", 32'(data_valid), 32'h0);
        wait_clk(1);
        check("lat_valid_pulse", 32'(data_valid), 32'h1);
        check("lat_data_out", 32'(data_out), 32'h5A);
        check("lat_busy_low", 32'(busy), 32'h0);
        wait_clk(1);
        check("lat_valid_width", 32'(data_valid), 32'h0);
        wait_clk(4);
        check("restart_valid_cnt", 32'(valid_total - v0), 32'd1);
        check("restart_err_total", 32'(err_total - e0), 32'd1);

        // Extra SCL rise after the pad bit aborts the frame
        v0 = valid_total;
        e0 = err_total;
        start_cond(1'b1);
        for (int i = 0; i < SIZE; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        stop_cond();
        wait_clk(6);
        check("extra_err_cnt", 32'(err_total - e0), 32'd1);
        check("extra_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("extra_data_held", 32'(data_out), 32'h5A);
        check("extra_busy", 32'(busy), 32'h0);

        // Reset mid-frame, random traffic without START, then a good frame
        v0 = valid_total;
        e0 = err_total;
        start_cond(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_clk(1);
        reset_n = 1'b0;
        wait_clk(2);
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_state", 32'(state_o), 32'h0);
        SDA = 1'b1;
        SCL = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            SCL = 1'b0;
            wait_clk(1);
            SDA = 1'($urandom_range(0, 1));
            wait_clk(1);
            SCL = 1'b1;
            wait_clk($urandom_range(2, 3));
        end
        SCL = 1'b0;
        SDA = 1'b1;
        wait_clk(2);
        SCL = 1'b1;
        wait_clk(6);
        check("noise_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("noise_err_cnt", 32'(err_total - e0), 32'd0);
        check("noise_busy", 32'(busy), 32'h0);
        check("noise_data_out", 32'(data_out), 32'h0);
        v0 = valid_total;
        send_frame(8'h42, 1'b0, 1'b1);
        wait_clk(6);
        check("post_rst_valid", 32'(valid_total - v0), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h42);

        // Whole-run properties
        check("valid_err_overlap", 32'(both_total), 32'd0);
        check("data_out_changed_without_valid", 32'(dout_chg_total), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
